mem_port_arbiter: RTL and testbench

//   Parametrised N-port arbiter in front of the single-ported main memory; generalises the fixed imem/dmem mux.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter_grant.sv | 38 +++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types, mode constants and index-width helper for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_HOLD
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client request/response and memory-side signal bundle for the arbiter
interface mem_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [NUM_PORTS-1:0]        rsp_stall;
    logic [NUM_PORTS-1:0]        flush;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_re;
    logic                        mem_wr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ready;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_stall, flush, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_data, mem_addr, mem_re, mem_wr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_stall, flush, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_data, mem_addr, mem_re, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// rtl/mem_port_arbiter_grant.sv - combinational one-hot grant selection, fixed priority or round-robin
module arb_grant
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = ARB_FIXED,
    localparam int IW       = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IW-1:0]        idx
);

    logic          found;
    logic [IW-1:0] pos;

    // Fixed mode scans from index 0; round-robin scans from ptr and wraps.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_RR) begin
                pos = IW'((int'(ptr) + k) % NUM_PORTS);
            end else begin
                pos = IW'(k);
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port arbiter in front of single-ported memory, one transaction in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        grant_idx;
    logic [NUM_PORTS-1:0] grant;
    logic                 we_q;
    logic                 flushed_q;
    logic                 accept;
    logic                 owner_flush;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    arb_grant #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_grant (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.mem_re    = 1'b0;
        bus.mem_wr    = 1'b0;
        owner_flush   = bus.flush[owner_q];
        case (state_q)
            ARB_IDLE: begin
                bus.req_ready = grant;
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                bus.mem_re = ~we_q;
                bus.mem_wr = we_q;
                if (bus.mem_ready) begin
                    state_d = (flushed_q || owner_flush) ? ARB_IDLE : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (!bus.rsp_stall[owner_q] || owner_flush) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // flushed_q remembers an owner flush seen in any BUSY cycle, not just the completing one.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            we_q       <= 1'b0;
            flushed_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                owner_q   <= grant_idx;
                we_q      <= bus.req_we[grant_idx];
                addr_q    <= addr_arr[grant_idx];
                wdata_q   <= wdata_arr[grant_idx];
                flushed_q <= 1'b0;
                rr_ptr_q  <= (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == ARB_BUSY) begin
                if (owner_flush) begin
                    flushed_q <= 1'b1;
                end
                if (bus.mem_ready) begin
                    rsp_data_q <= we_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench: directed scenarios plus randomized round-robin traffic
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int b_ptr    = 0;

    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) a_if ();
    mem_port_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) b_if ();

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if.slave)
    );
    mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if.req_valid = '0; a_if.req_we = '0; a_if.req_addr = '0; a_if.req_wdata = '0;
        a_if.rsp_stall = '0; a_if.flush = '0; a_if.mem_rdata = '0; a_if.mem_ready = 1'b0;
        b_if.req_valid = '0; b_if.req_we = '0; b_if.req_addr = '0; b_if.req_wdata = '0;
        b_if.rsp_stall = '0; b_if.flush = '0; b_if.mem_rdata = '0; b_if.mem_ready = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_if.req_ready, a_if.rsp_valid, a_if.mem_re, a_if.mem_wr} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {a_if.req_ready, a_if.rsp_valid, a_if.mem_re, a_if.mem_wr});
        end
        checks++;
        if ({a_if.mem_addr, a_if.mem_wdata, a_if.rsp_data} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {a_if.mem_addr, a_if.mem_wdata, a_if.rsp_data});
        end
        a_if.req_valid = 2'b01; a_if.req_addr = {32'h0, 32'h123};
        #1;
        checks++;
        if (a_if.req_ready !== 2'b01) begin failures++; $display("FAIL reset_grant got=%b exp=01", a_if.req_ready); end
        cyc();
        a_if.req_valid = 2'b00;
        #1;
        checks++;
        if ({a_if.mem_re, a_if.mem_addr} !== {1'b1, 32'h123}) begin
            failures++; $display("FAIL busy_before_rst got=%h exp=%h", {a_if.mem_re, a_if.mem_addr}, {1'b1, 32'h123});
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        a_if.req_valid = 2'b01;
        #1;
        checks++;
        if ({a_if.mem_re, a_if.rsp_valid, a_if.req_ready} !== 5'b0_00_01) begin
            failures++; $display("FAIL reset_mid_busy got=%b exp=00001", {a_if.mem_re, a_if.rsp_valid, a_if.req_ready});
        end
        a_if.req_valid = 2'b00;
        b_ptr = 0;
    endtask

    task automatic test_read();
        a_if.req_valid = 2'b10; a_if.req_we = 2'b00; a_if.req_addr = {32'h100, 32'h0};
        #1;
        checks++;
        if (a_if.req_ready !== 2'b10) begin failures++; $display("FAIL read_grant got=%b exp=10", a_if.req_ready); end
        cyc();
        a_if.req_valid = 2'b00;
        cyc();
        a_if.mem_ready = 1'b1; a_if.mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({a_if.mem_re, a_if.mem_wr, a_if.mem_addr} !== {2'b10, 32'h100}) begin
            failures++; $display("FAIL read_strobe got=%h exp=%h", {a_if.mem_re, a_if.mem_wr, a_if.mem_addr}, {2'b10, 32'h100});
        end
        cyc();
        a_if.mem_ready = 1'b0; a_if.mem_rdata = 32'h0;
        #1;
        checks++;
        if ({a_if.rsp_valid, a_if.rsp_data, a_if.mem_re} !== {2'b10, 32'hDEADBEEF, 1'b0}) begin
            failures++; $display("FAIL read_rsp got=%h exp=%h", {a_if.rsp_valid, a_if.rsp_data, a_if.mem_re}, {2'b10, 32'hDEADBEEF, 1'b0});
        end
        cyc();
        checks++;
        if (a_if.rsp_valid !== 2'b00) begin failures++; $display("FAIL read_rsp_one_cycle got=%b exp=00", a_if.rsp_valid); end
    endtask

    task automatic test_fixed_priority();
        a_if.req_valid = 2'b11; a_if.req_we = 2'b00; a_if.req_addr = {32'h20, 32'h10};
        #1;
        checks++;
        if (a_if.req_ready !== 2'b01) begin failures++; $display("FAIL fixed_first got=%b exp=01", a_if.req_ready); end
        cyc();
        a_if.req_valid = 2'b10; a_if.mem_ready = 1'b1; a_if.mem_rdata = 32'hA;
        #1;
        checks++;
        if ({a_if.req_ready, a_if.mem_addr} !== {2'b00, 32'h10}) begin
            failures++; $display("FAIL fixed_busy got=%h exp=%h", {a_if.req_ready, a_if.mem_addr}, {2'b00, 32'h10});
        end
        cyc();
        a_if.mem_ready = 1'b0;
        #1;
        checks++;
        if ({a_if.rsp_valid, a_if.rsp_data, a_if.req_ready} !== {2'b01, 32'hA, 2'b00}) begin
            failures++; $display("FAIL fixed_rsp0 got=%h exp=%h", {a_if.rsp_valid, a_if.rsp_data, a_if.req_ready}, {2'b01, 32'hA, 2'b00});
        end
        cyc();
        checks++;
        if (a_if.req_ready !== 2'b10) begin failures++; $display("FAIL fixed_second got=%b exp=10", a_if.req_ready); end
        cyc();
        a_if.req_valid = 2'b00; a_if.mem_ready = 1'b1; a_if.mem_rdata = 32'hB;
        #1;
        checks++;
        if (a_if.mem_addr !== 32'h20) begin failures++; $display("FAIL fixed_addr1 got=%h exp=20", a_if.mem_addr); end
        cyc();
        a_if.mem_ready = 1'b0;
        #1;
        checks++;
        if ({a_if.rsp_valid, a_if.rsp_data} !== {2'b10, 32'hB}) begin
            failures++; $display("FAIL fixed_rsp1 got=%h exp=%h", {a_if.rsp_valid, a_if.rsp_data}, {2'b10, 32'hB});
        end
        cyc();
    endtask

    task automatic test_hold();
        a_if.req_valid = 2'b01; a_if.req_we = 2'b00; a_if.req_addr = {32'h0, 32'h30};
        cyc();
        a_if.req_valid = 2'b00; a_if.mem_ready = 1'b1; a_if.mem_rdata = 32'h1234; a_if.rsp_stall = 2'b01;
        cyc();
        a_if.mem_ready = 1'b0; a_if.mem_rdata = 32'h5555AAAA;
        for (int i = 0; i < 4; i++) begin
            a_if.rsp_stall = (i < 3) ? 2'b01 : 2'b00;
            a_if.req_valid = 2'b10;
            #1;
            checks++;
            if ({a_if.rsp_valid, a_if.rsp_data, a_if.mem_re, a_if.mem_wr, a_if.req_ready} !== {2'b01, 32'h1234, 2'b00, 2'b00}) begin
                failures++; $display("FAIL hold_cycle%0d got=%h exp=%h", i,
                    {a_if.rsp_valid, a_if.rsp_data, a_if.mem_re, a_if.mem_wr, a_if.req_ready}, {2'b01, 32'h1234, 2'b00, 2'b00});
            end
            cyc();
        end
        checks++;
        if ({a_if.rsp_valid, a_if.req_ready} !== 4'b00_10) begin
            failures++; $display("FAIL hold_release got=%b exp=0010", {a_if.rsp_valid, a_if.req_ready});
        end
        a_if.req_valid = 2'b00;
        cyc();
        checks++;
        if ({a_if.mem_re, a_if.mem_wr} !== 2'b00) begin
            failures++; $display("FAIL withdrawn_req got=%b exp=00", {a_if.mem_re, a_if.mem_wr});
        end
    endtask

    task automatic test_flush();
        a_if.req_valid = 2'b01; a_if.req_we = 2'b01; a_if.req_addr = {32'h0, 32'h40}; a_if.req_wdata = {32'h0, 32'h5};
        cyc();
        a_if.req_valid = 2'b00; a_if.flush = 2'b01;
        #1;
        checks++;
        if ({a_if.mem_wr, a_if.mem_re, a_if.mem_wdata} !== {2'b10, 32'h5}) begin
            failures++; $display("FAIL flush_write got=%h exp=%h", {a_if.mem_wr, a_if.mem_re, a_if.mem_wdata}, {2'b10, 32'h5});
        end
        cyc();
        a_if.flush = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({a_if.mem_wr, a_if.mem_addr, a_if.rsp_valid} !== {1'b1, 32'h40, 2'b00}) begin
                failures++; $display("FAIL flush_busy%0d got=%h exp=%h", i, {a_if.mem_wr, a_if.mem_addr, a_if.rsp_valid}, {1'b1, 32'h40, 2'b00});
            end
            cyc();
        end
        a_if.mem_ready = 1'b1;
        cyc();
        a_if.mem_ready = 1'b0; a_if.req_we = 2'b00; a_if.req_valid = 2'b10;
        #1;
        checks++;
        if ({a_if.rsp_valid, a_if.mem_wr, a_if.req_ready} !== 5'b00_0_10) begin
            failures++; $display("FAIL flush_idle got=%b exp=00010", {a_if.rsp_valid, a_if.mem_wr, a_if.req_ready});
        end
        a_if.req_valid = 2'b00;
    endtask

    task automatic test_round_robin();
        int exp;
        b_if.req_valid = 4'hF; b_if.req_we = 4'h0;
        for (int i = 0; i < 4; i++) b_if.req_addr[i*32 +: 32] = 32'h200 + 32'(i);
        for (int n = 0; n < 5; n++) begin
            exp = n % 4;
            #1;
            checks++;
            if (b_if.req_ready !== 4'(1 << exp)) begin
                failures++; $display("FAIL rr_order%0d got=%b exp=%b", n, b_if.req_ready, 4'(1 << exp));
            end
            cyc();
            b_ptr = (exp + 1) % 4;
            b_if.mem_ready = 1'b1; b_if.mem_rdata = 32'(n);
            #1;
            checks++;
            if (b_if.mem_addr !== 32'h200 + 32'(exp)) begin
                failures++; $display("FAIL rr_addr%0d got=%h exp=%h", n, b_if.mem_addr, 32'h200 + 32'(exp));
            end
            cyc();
            b_if.mem_ready = 1'b0;
            cyc();
        end
        b_if.req_valid = 4'h0;
    endtask

    task automatic test_random();
        logic [3:0]  vld, we, onehot, fl;
        logic [31:0] addr [4];
        logic [31:0] wdata [4];
        logic [31:0] rdata, exp_data;
        int w, lat, mode, stall;
        for (int t = 0; t < 40; t++) begin
            vld = 4'($urandom_range(1, 15));
            we  = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                addr[i] = $urandom; wdata[i] = $urandom;
                b_if.req_addr[i*32 +: 32] = addr[i]; b_if.req_wdata[i*32 +: 32] = wdata[i];
            end
            b_if.req_valid = vld; b_if.req_we = we;
            w = -1;
            for (int k = 0; k < 4; k++) if (w < 0 && vld[(b_ptr + k) % 4]) w = (b_ptr + k) % 4;
            onehot = 4'(1 << w);
            #1;
            checks++;
            if (b_if.req_ready !== onehot) begin
                failures++; $display("FAIL rand%0d_grant got=%b exp=%b", t, b_if.req_ready, onehot);
            end
            cyc();
            b_ptr = (w + 1) % 4;
            b_if.req_valid = 4'h0;
            lat = $urandom_range(0, 3); mode = $urandom_range(0, 3); rdata = $urandom;
            for (int c = 0; c <= lat; c++) begin
                fl = 4'h0;
                if (mode == 1 && c == 0) fl = onehot;
                if (mode == 2 && c == lat) fl = onehot;
                if (mode == 3 && c == lat) fl = 4'(1 << ((w + 1) % 4));
                b_if.flush = fl;
                b_if.mem_ready = (c == lat);
                b_if.mem_rdata = (c == lat) ? rdata : $urandom;
                #1;
                checks++;
                if ({b_if.mem_re, b_if.mem_wr, b_if.mem_addr, b_if.mem_wdata} !== {~we[w], we[w], addr[w], wdata[w]}) begin
                    failures++; $display("FAIL rand%0d_mem got=%h exp=%h", t,
                        {b_if.mem_re, b_if.mem_wr, b_if.mem_addr, b_if.mem_wdata}, {~we[w], we[w], addr[w], wdata[w]});
                end
                cyc();
            end
            b_if.flush = 4'h0; b_if.mem_ready = 1'b0;
            exp_data = we[w] ? 32'h0 : rdata;
            if (mode == 1 || mode == 2) begin
                #1;
                checks++;
                if ({b_if.rsp_valid, b_if.mem_re, b_if.mem_wr} !== 6'b0) begin
                    failures++; $display("FAIL rand%0d_flushed got=%b exp=0", t, {b_if.rsp_valid, b_if.mem_re, b_if.mem_wr});
                end
            end else begin
                stall = $urandom_range(0, 2);
                for (int h = 0; h <= stall; h++) begin
                    b_if.rsp_stall = (h < stall) ? (4'($urandom) | onehot) : (4'($urandom) & ~onehot);
                    #1;
                    checks++;
                    if ({b_if.rsp_valid, b_if.rsp_data} !== {onehot, exp_data}) begin
                        failures++; $display("FAIL rand%0d_rsp%0d got=%h exp=%h", t, h, {b_if.rsp_valid, b_if.rsp_data}, {onehot, exp_data});
                    end
                    cyc();
                end
                b_if.rsp_stall = 4'h0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_fixed_priority();
        test_hold();
        test_flush();
        test_round_robin();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
